// File: rtl/active_list_commit_unit.sv
// In-order retirement tracker: circular mapping table plus a small result queue.
// Results retire in program order; a flush walks youngest-to-oldest restoring saved pairings.
module active_list_commit_unit #(
    parameter int AL_DEPTH   = 32,
    parameter int DQ_DEPTH   = 8,
    parameter int DATA_WIDTH = 32,
    parameter int PHYS_W     = 6,
    parameter int LOG_W      = 5,
    localparam int TAG_W     = $clog2(AL_DEPTH),
    localparam int QIDX_W    = $clog2(DQ_DEPTH),
    localparam int CNT_W     = TAG_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  add_mapping,
    input  logic [PHYS_W-1:0]     add_prev_phys,
    input  logic [LOG_W-1:0]      add_prev_log,
    output logic [TAG_W-1:0]      alloc_tag,
    output logic                  al_full,
    output logic                  al_empty,
    input  logic                  wb_valid,
    input  logic [TAG_W-1:0]      wb_tag,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic [PHYS_W-1:0]     wb_phys,
    input  logic [DATA_WIDTH-1:0] wb_mem_addr,
    input  logic                  wb_reg_or_mem,
    output logic                  wb_ready,
    output logic                  commit_valid,
    output logic [DATA_WIDTH-1:0] commit_data,
    output logic [PHYS_W-1:0]     commit_reg_addr,
    output logic [DATA_WIDTH-1:0] commit_mem_addr,
    output logic                  commit_reg_or_mem,
    input  logic                  advance_head,
    output logic                  flush_valid,
    output logic [PHYS_W-1:0]     flush_phys,
    output logic [LOG_W-1:0]      flush_log,
    output logic                  flush_busy
);

    logic [TAG_W-1:0]      head;
    logic [TAG_W-1:0]      tail;
    logic [TAG_W-1:0]      tail_prev;
    logic [CNT_W-1:0]      count;

    logic [AL_DEPTH-1:0]   ent_valid;
    logic [AL_DEPTH-1:0]   ent_done;
    logic [PHYS_W-1:0]     ent_phys [AL_DEPTH];
    logic [LOG_W-1:0]      ent_log  [AL_DEPTH];
    logic [QIDX_W-1:0]     ent_qidx [AL_DEPTH];

    logic [DQ_DEPTH-1:0]   slot_busy;
    logic [DQ_DEPTH-1:0]   slot_rom;
    logic [DATA_WIDTH-1:0] slot_data [DQ_DEPTH];
    logic [PHYS_W-1:0]     slot_phys [DQ_DEPTH];
    logic [DATA_WIDTH-1:0] slot_addr [DQ_DEPTH];

    logic [QIDX_W-1:0]     free_slot;
    logic [QIDX_W-1:0]     head_slot;
    logic                  do_alloc;
    logic                  do_wb;
    logic                  do_commit;

    assign tail_prev = tail - TAG_W'(1);
    assign alloc_tag = tail;
    assign al_full   = (count == CNT_W'(AL_DEPTH));
    assign al_empty  = (count == '0);
    assign wb_ready  = ~&slot_busy;
    assign head_slot = ent_qidx[head];

    // Lowest-index free slot wins: scanning downward lets the last hit stand.
    always_comb begin
        free_slot = '0;
        for (int i = DQ_DEPTH - 1; i >= 0; i--) begin
            if (!slot_busy[i]) free_slot = QIDX_W'(i);
        end
    end

    assign do_alloc  = add_mapping && !al_full && !flush_busy && !flush;
    assign do_wb     = wb_valid && wb_ready && ent_valid[wb_tag] && !flush_busy && !flush;
    assign commit_valid = !al_empty && ent_done[head] && !flush_busy;
    assign do_commit = advance_head && commit_valid;

    assign commit_data       = commit_valid ? slot_data[head_slot] : '0;
    assign commit_reg_addr   = commit_valid ? slot_phys[head_slot] : '0;
    assign commit_mem_addr   = commit_valid ? slot_addr[head_slot] : '0;
    assign commit_reg_or_mem = commit_valid ? slot_rom[head_slot]  : 1'b0;

    assign flush_valid = flush_busy && !al_empty;
    assign flush_phys  = flush_valid ? ent_phys[tail_prev] : '0;
    assign flush_log   = flush_valid ? ent_log[tail_prev]  : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            ent_valid  <= '0;
            ent_done   <= '0;
            slot_busy  <= '0;
            flush_busy <= 1'b0;
        end else if (flush_busy) begin
            // Walk back from the youngest entry; the busy cycle after the last one ends the walk.
            if (al_empty) begin
                flush_busy <= 1'b0;
            end else begin
                ent_valid[tail_prev] <= 1'b0;
                ent_done[tail_prev]  <= 1'b0;
                if (ent_done[tail_prev]) slot_busy[ent_qidx[tail_prev]] <= 1'b0;
                tail  <= tail_prev;
                count <= count - CNT_W'(1);
            end
        end else begin
            if (do_wb) begin
                slot_busy[free_slot] <= 1'b1;
                ent_done[wb_tag]     <= 1'b1;
            end
            if (do_commit) begin
                slot_busy[head_slot] <= 1'b0;
                ent_valid[head]      <= 1'b0;
                ent_done[head]       <= 1'b0;
                head                 <= head + TAG_W'(1);
            end
            if (do_alloc) begin
                ent_valid[tail] <= 1'b1;
                ent_done[tail]  <= 1'b0;
                tail            <= tail + TAG_W'(1);
            end
            count <= count + CNT_W'(do_alloc) - CNT_W'(do_commit);
            if (flush) flush_busy <= 1'b1;
        end
    end

    // Payload storage needs no reset: every read is qualified by valid/done/busy.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            ent_phys[tail] <= add_prev_phys;
            ent_log[tail]  <= add_prev_log;
        end
        if (do_wb) begin
            ent_qidx[wb_tag]     <= free_slot;
            slot_data[free_slot] <= wb_data;
            slot_phys[free_slot] <= wb_phys;
            slot_addr[free_slot] <= wb_mem_addr;
            slot_rom[free_slot]  <= wb_reg_or_mem;
        end
    end

endmodule

// File: tb/tb_active_list_commit_unit.sv
// Bench for active_list_commit_unit: directed plan steps then random traffic,
// every cycle compared against a program-order queue model.
module tb_active_list_commit_unit;

    logic        clk = 1'b0;
    logic        rst_n, flush, add_mapping, wb_valid, wb_reg_or_mem, advance_head;
    logic [5:0]  add_prev_phys, wb_phys;
    logic [4:0]  add_prev_log, wb_tag;
    logic [31:0] wb_data, wb_mem_addr;
    logic [4:0]  alloc_tag;
    logic        al_full, al_empty, wb_ready, commit_valid, commit_reg_or_mem;
    logic [31:0] commit_data, commit_mem_addr;
    logic [5:0]  commit_reg_addr, flush_phys;
    logic [4:0]  flush_log;
    logic        flush_valid, flush_busy;

    active_list_commit_unit dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .add_mapping(add_mapping), .add_prev_phys(add_prev_phys), .add_prev_log(add_prev_log),
        .alloc_tag(alloc_tag), .al_full(al_full), .al_empty(al_empty),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_phys(wb_phys),
        .wb_mem_addr(wb_mem_addr), .wb_reg_or_mem(wb_reg_or_mem), .wb_ready(wb_ready),
        .commit_valid(commit_valid), .commit_data(commit_data), .commit_reg_addr(commit_reg_addr),
        .commit_mem_addr(commit_mem_addr), .commit_reg_or_mem(commit_reg_or_mem),
        .advance_head(advance_head), .flush_valid(flush_valid), .flush_phys(flush_phys),
        .flush_log(flush_log), .flush_busy(flush_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tag;
        int pphys;
        int plog;
        bit done;
        int slot;
    } ent_t;

    ent_t        q[$];
    bit          sbusy [8];
    logic [31:0] sdata [8];
    logic [31:0] saddr [8];
    int          sphys [8];
    bit          srom  [8];
    int          mtail;
    bit          fbusy;
    int          checks = 0;
    int          failures = 0;
    bit          chk_en;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 8; i++) sbusy[i] = 0;
        mtail = 0;
        fbusy = 0;
    endtask

    function automatic bit m_ready();
        for (int i = 0; i < 8; i++) if (!sbusy[i]) return 1;
        return 0;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < 8; i++) if (!sbusy[i]) return i;
        return 0;
    endfunction

    function automatic bit m_cv();
        return q.size() > 0 && q[0].done && !fbusy;
    endfunction

    task automatic check_outputs();
        bit cv, fv;
        int s;
        cv = m_cv();
        fv = fbusy && q.size() > 0;
        s  = cv ? q[0].slot : 0;
        chk("alloc_tag", alloc_tag, mtail);
        chk("al_full", al_full, q.size() == 32);
        chk("al_empty", al_empty, q.size() == 0);
        chk("wb_ready", wb_ready, m_ready());
        chk("commit_valid", commit_valid, cv);
        chk("commit_data", commit_data, cv ? sdata[s] : 32'h0);
        chk("commit_reg_addr", commit_reg_addr, cv ? sphys[s] : 0);
        chk("commit_mem_addr", commit_mem_addr, cv ? saddr[s] : 32'h0);
        chk("commit_reg_or_mem", commit_reg_or_mem, cv ? srom[s] : 1'b0);
        chk("flush_valid", flush_valid, fv);
        chk("flush_phys", flush_phys, fv ? q[$].pphys : 0);
        chk("flush_log", flush_log, fv ? q[$].plog : 0);
        chk("flush_busy", flush_busy, fbusy);
    endtask

    task automatic model_update();
        int idx, s;
        bit do_wb, do_commit, do_alloc;
        ent_t e;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (fbusy) begin
            if (q.size() == 0) fbusy = 0;
            else begin
                e = q.pop_back();
                if (e.done) sbusy[e.slot] = 0;
                mtail = (mtail + 31) % 32;
            end
            return;
        end
        idx = -1;
        foreach (q[i]) if (q[i].tag == int'(wb_tag)) idx = i;
        do_wb     = wb_valid && m_ready() && idx >= 0 && !flush;
        do_commit = advance_head && m_cv();
        do_alloc  = add_mapping && q.size() < 32 && !flush;
        s = m_free();
        if (do_wb) begin
            q[idx].done = 1;
            q[idx].slot = s;
            sbusy[s] = 1;
            sdata[s] = wb_data;
            saddr[s] = wb_mem_addr;
            sphys[s] = wb_phys;
            srom[s]  = wb_reg_or_mem;
        end
        if (do_commit) begin
            sbusy[q[0].slot] = 0;
            void'(q.pop_front());
        end
        if (do_alloc) begin
            e.tag = mtail; e.pphys = add_prev_phys; e.plog = add_prev_log; e.done = 0; e.slot = 0;
            q.push_back(e);
            mtail = (mtail + 1) % 32;
        end
        if (flush) fbusy = 1;
    endtask

    task automatic idle();
        rst_n = 1; flush = 0; add_mapping = 0; wb_valid = 0; advance_head = 0;
        add_prev_phys = 0; add_prev_log = 0; wb_tag = 0; wb_data = 0; wb_phys = 0;
        wb_mem_addr = 0; wb_reg_or_mem = 0;
    endtask

    task automatic step();
        #1;
        if (chk_en) check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
        idle();
    endtask

    task automatic do_reset();
        rst_n = 0;
        step();
    endtask

    task automatic alloc(input int pphys, input int plog);
        add_mapping = 1; add_prev_phys = 6'(pphys); add_prev_log = 5'(plog);
        step();
    endtask

    task automatic wb(input int tag, input logic [31:0] data);
        wb_valid = 1; wb_tag = 5'(tag); wb_data = data; wb_phys = 6'(tag + 3);
        wb_mem_addr = data ^ 32'h1000; wb_reg_or_mem = data[0];
        step();
    endtask

    task automatic drain_flush();
        flush = 1;
        step();
        for (int i = 0; i < 40 && flush_busy; i++) step();
        chk("drain_done", flush_busy, 1'b0);
    endtask

    int got_phys[$];
    int tg;

    initial begin
        idle();
        chk_en = 0;
        @(negedge clk);
        do_reset();
        chk_en = 1;

        // 1: reset state and first allocations
        chk("rst_empty", al_empty, 1'b1);
        chk("rst_ready", wb_ready, 1'b1);
        for (int i = 0; i < 3; i++) alloc(10 + i, i);
        chk("tp1_tag", alloc_tag, 5'd3);
        chk("tp1_cv", commit_valid, 1'b0);

        // 2: out-of-order write-back retires in order
        wb(1, 32'hAA);
        wb(0, 32'h55);
        chk("tp2_cv", commit_valid, 1'b1);
        chk("tp2_d0", commit_data, 32'h55);
        advance_head = 1; step();
        chk("tp2_d1", commit_data, 32'hAA);
        advance_head = 1; step();
        drain_flush();

        // 3: fill, overflow ignored, wrap
        do_reset();
        for (int i = 0; i < 32; i++) alloc(i, i % 32);
        chk("tp3_full", al_full, 1'b1);
        alloc(63, 31);
        chk("tp3_tail", alloc_tag, 5'd0);
        wb(0, 32'h1234);
        advance_head = 1; step();
        alloc(40, 7);
        chk("tp3_wrap", alloc_tag, 5'd1);
        chk("tp3_full2", al_full, 1'b1);

        // 4: queue exhaustion, drop, reuse of freed slot
        for (int i = 1; i <= 8; i++) wb(i, 32'h100 + i);
        chk("tp4_notready", wb_ready, 1'b0);
        wb(9, 32'hDEAD);
        advance_head = 1; step();
        chk("tp4_ready", wb_ready, 1'b1);
        wb(9, 32'hBEEF);
        chk("tp4_full_again", wb_ready, 1'b0);
        for (int i = 2; i <= 9; i++) begin
            chk("tp4_order", commit_data, (i == 9) ? 32'hBEEF : 32'h100 + i);
            advance_head = 1; step();
        end
        drain_flush();

        // 5: flush walk order
        do_reset();
        for (int i = 0; i < 3; i++) alloc(20 + i, 4 + i);
        flush = 1; step();
        for (int i = 0; i < 10 && flush_busy; i++) begin
            #1;
            if (flush_valid) got_phys.push_back(int'(flush_phys));
            step();
        end
        chk("tp5_n", got_phys.size(), 3);
        for (int i = 0; i < 3 && i < got_phys.size(); i++) chk("tp5_phys", got_phys[i], 22 - i);
        chk("tp5_empty", al_empty, 1'b1);
        chk("tp5_ready", wb_ready, 1'b1);

        // 6: reset mid-flush
        for (int i = 0; i < 4; i++) alloc(30 + i, i);
        flush = 1; step();
        step();
        do_reset();
        chk("tp6_busy", flush_busy, 1'b0);
        chk("tp6_tail", alloc_tag, 5'd0);
        chk("tp6_ready", wb_ready, 1'b1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            add_mapping = ($urandom_range(0, 99) < 55);
            add_prev_phys = 6'($urandom_range(0, 63));
            add_prev_log = 5'($urandom_range(0, 31));
            advance_head = ($urandom_range(0, 99) < 45);
            flush = ($urandom_range(0, 99) < 2);
            tg = -1;
            if ($urandom_range(0, 99) < 60) begin
                for (int k = 0; k < 4 && tg < 0 && q.size() > 0; k++) begin
                    int j = $urandom_range(0, q.size() - 1);
                    if (!q[j].done) tg = q[j].tag;
                end
                if (tg < 0 && q.size() < 32) tg = (mtail + $urandom_range(0, 31 - q.size())) % 32;
            end
            if (tg >= 0) begin
                wb_valid = 1; wb_tag = 5'(tg); wb_data = $urandom; wb_phys = 6'($urandom_range(0, 63));
                wb_mem_addr = $urandom; wb_reg_or_mem = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 999) < 2) rst_n = 0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
